// File: rtl/ic_scan_seq.sv
// Address/enable sequencer for a 74138-style 3-to-8 decoder: scans addresses
// 0..last with a blanking gap (decoder disabled) before every active slot.
module ic_scan_seq #(
  parameter int DIV_W = 16,
  parameter int BLK_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             step,
  input  logic [2:0]       last,
  input  logic [DIV_W-1:0] div,
  input  logic [BLK_W-1:0] blank_cyc,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             g1,
  output logic             g2a,
  output logic             g2b,
  output logic             frame,
  output logic             busy
);

  localparam int CNT_W = (DIV_W > BLK_W) ? DIV_W : BLK_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_ACTIVE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_addr;
  logic               r_oneshot;
  logic [DIV_W-1:0]   r_div;
  logic [BLK_W-1:0]   r_blk;
  logic               r_dec_en;
  logic               r_frame;
  logic               r_busy;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [2:0]         w_addr_nxt;
  logic               w_oneshot_nxt;
  logic               w_latch;
  logic               w_wrap;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_addr_nxt    = r_addr;
    w_oneshot_nxt = r_oneshot;
    w_latch       = 1'b0;
    w_wrap        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state_nxt = S_BLANK;
          w_cnt_nxt   = '0;
          w_latch     = 1'b1;
        end else if (step) begin
          w_state_nxt   = S_BLANK;
          w_cnt_nxt     = '0;
          w_oneshot_nxt = 1'b1;
          w_latch       = 1'b1;
        end
      end
      S_BLANK: begin
        if (r_cnt == CNT_W'(r_blk)) begin
          w_state_nxt = S_ACTIVE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_ACTIVE: begin
        if (r_cnt == CNT_W'(r_div)) begin
          w_cnt_nxt = '0;
          // Address moves only as the decoder turns off, so y never glitches.
          if (r_addr >= last) begin
            w_addr_nxt = 3'd0;
            w_wrap     = 1'b1;
          end else begin
            w_addr_nxt = r_addr + 3'd1;
          end
          if (r_oneshot) begin
            w_state_nxt   = S_IDLE;
            w_oneshot_nxt = 1'b0;
          end else if (!en) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_BLANK;
            w_latch     = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= 3'd0;
      r_oneshot <= 1'b0;
      r_div     <= '0;
      r_blk     <= '0;
      r_dec_en  <= 1'b0;
      r_frame   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_addr    <= w_addr_nxt;
      r_oneshot <= w_oneshot_nxt;
      if (w_latch) begin
        r_div <= div;
        r_blk <= blank_cyc;
      end
      r_dec_en  <= (w_state_nxt == S_ACTIVE);
      r_frame   <= w_wrap;
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  assign a     = r_addr[0];
  assign b     = r_addr[1];
  assign c     = r_addr[2];
  assign g1    = r_dec_en;
  assign g2a   = ~r_dec_en;
  assign g2b   = ~r_dec_en;
  assign frame = r_frame;
  assign busy  = r_busy;

endmodule

// File: tb/tb_ic_scan_seq.sv
// Directed bench for ic_scan_seq: expected slot/address/frame patterns are
// computed from cycle index k after the starting edge.
module tb_ic_scan_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        step;
  logic [2:0]  last;
  logic [15:0] div;
  logic [3:0]  blank_cyc;
  logic        a, b, c, g1, g2a, g2b, frame, busy;

  int n_vec = 0;
  int n_err = 0;

  wire [2:0] addr = {c, b, a};
  wire [2:0] gen  = {g1, g2a, g2b};

  ic_scan_seq #(.DIV_W(16), .BLK_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .step(step), .last(last), .div(div),
    .blank_cyc(blank_cyc), .a(a), .b(b), .c(c), .g1(g1), .g2a(g2a),
    .g2b(g2b), .frame(frame), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] gexp(input logic on);
    return on ? 3'b100 : 3'b011;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; step = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Compare one cycle of outputs against expected enable/address/frame/busy.
  task automatic cmp(input string tag, input int k, input logic e_on,
                     input logic [2:0] e_addr, input logic e_frame,
                     input logic e_busy);
    n_vec++;
    if (gen !== gexp(e_on) || addr !== e_addr || frame !== e_frame ||
        busy !== e_busy) begin
      n_err++;
      $display("FAIL %s k=%0d got g=%b addr=%0d frame=%b busy=%b exp g=%b addr=%0d frame=%b busy=%b",
               tag, k, gen, addr, frame, busy, gexp(e_on), e_addr, e_frame, e_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; step = 1'b0;
    last = 3'd7; div = 16'd100; blank_cyc = 4'd0;
    #1;
    cmp("reset_init", 0, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    en = 1'b1;
    for (int k = 0; k < 6; k++) @(negedge clk);
    // k=5: inside the 101-cycle active slot at address 0
    cmp("reset_pre_active", 5, 1'b1, 3'd0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    cmp("reset_async", 0, 1'b0, 3'd0, 1'b0, 1'b0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    logic [2:0] prev;
    do_reset();
    last = 3'd7; div = 16'd3; blank_cyc = 4'd0;
    en = 1'b1; step = 1'b1;   // en wins; must not turn into a one-shot
    prev = 3'd0;
    for (int k = 0; k < 85; k++) begin
      @(negedge clk);
      step = 1'b0;
      cmp("free_run", k, (k % 5) != 0, 3'((k / 5) % 8),
          ((k % 40) == 0) && (k > 0), 1'b1);
      n_vec++;
      if (addr !== prev && g1 !== 1'b0) begin
        n_err++;
        $display("FAIL free_run_bbm k=%0d got g1=%b on addr change exp g1=0", k, g1);
      end
      prev = addr;
    end
    en = 1'b0;
  endtask

  task automatic test_short_cycle();
    do_reset();
    last = 3'd2; div = 16'd0; blank_cyc = 4'd2;
    en = 1'b1;
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      cmp("short_cycle", k, (k % 4) == 3, 3'((k / 4) % 3),
          ((k % 12) == 0) && (k > 0), 1'b1);
    end
    en = 1'b0;
  endtask

  task automatic test_single_step();
    do_reset();
    last = 3'd7; div = 16'd5; blank_cyc = 4'd1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      step = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        step = (k == 3);      // stray step while busy must be ignored
        cmp("single_step", n * 100 + k, (k >= 2) && (k < 8),
            (k < 8) ? 3'(n) : 3'(n + 1), 1'b0, k < 8);
      end
    end
    step = 1'b0;
  endtask

  task automatic test_mid_stop();
    do_reset();
    last = 3'd7; div = 16'd9; blank_cyc = 4'd0;
    en = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k <= 54)
        cmp("mid_stop", k, (k % 11) != 0, 3'(k / 11), 1'b0, 1'b1);
      else
        cmp("mid_stop_idle", k, 1'b0, 3'd5, 1'b0, 1'b0);
      if (k == 46) en = 1'b0;   // 2nd enabled cycle of the addr-4 slot
    end
  endtask

  task automatic test_last_shrink();
    int s;
    do_reset();
    last = 3'd7; div = 16'd3; blank_cyc = 4'd0;
    en = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      s = k / 5;
      cmp("last_shrink", k, (k % 5) != 0,
          (s <= 6) ? 3'(s) : 3'((s - 7) % 4), k == 35, 1'b1);
      if (k == 32) last = 3'd3;
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_short_cycle();
    test_single_step();
    test_mid_stop();
    test_last_shrink();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
